// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with configurable depth, stall/flush control and a
// youngest-wins forwarding lookup across every in-flight write.
module mem_wb_pipe #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic              mem_we,
   output logic [DATA_W-1:0] wb_wdata,
   output logic [ADDR_W-1:0] wb_waddr,
   output logic              wb_we,
   input  logic [ADDR_W-1:0] fwd_raddr1,
   input  logic [ADDR_W-1:0] fwd_raddr2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
   output logic [2:0]        pending
);

   logic              we_q   [STAGES];
   logic              we_d   [STAGES];
   logic [ADDR_W-1:0] addr_q [STAGES];
   logic [ADDR_W-1:0] addr_d [STAGES];
   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];

   // Flush beats stall; an invalid word is always stored as all zeros.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         we_d[i]   = we_q[i];
         addr_d[i] = addr_q[i];
         data_d[i] = data_q[i];
      end
      if (flush) begin
         for (int i = 0; i < STAGES; i++) begin
            we_d[i]   = 1'b0;
            addr_d[i] = '0;
            data_d[i] = '0;
         end
      end else if (!stall) begin
         we_d[0]   = mem_we;
         addr_d[0] = mem_we ? mem_waddr : '0;
         data_d[0] = mem_we ? mem_wdata : '0;
         for (int i = 1; i < STAGES; i++) begin
            we_d[i]   = we_q[i-1];
            addr_d[i] = addr_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) begin
            we_q[i]   <= 1'b0;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            we_q[i]   <= we_d[i];
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign wb_we    = we_q[STAGES-1];
   assign wb_waddr = addr_q[STAGES-1];
   assign wb_wdata = data_q[STAGES-1];

   // Scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (we_q[i] && (addr_q[i] == fwd_raddr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = data_q[i];
         end
         if (we_q[i] && (addr_q[i] == fwd_raddr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = data_q[i];
         end
      end
   end

   always_comb begin
      pending = 3'd0;
      for (int i = 0; i < STAGES; i++) begin
         pending = pending + 3'(we_q[i]);
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a 1-stage and a 3-stage instance share stimulus.
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush;
   logic [15:0] mem_wdata;
   logic [3:0]  mem_waddr;
   logic        mem_we;
   logic [3:0]  fwd_raddr1, fwd_raddr2;

   logic [15:0] o1_wdata, o3_wdata, o1_fdata1, o1_fdata2, o3_fdata1, o3_fdata2;
   logic [3:0]  o1_waddr, o3_waddr;
   logic        o1_we, o3_we, o1_hit1, o1_hit2, o3_hit1, o3_hit2;
   logic [2:0]  o1_pend, o3_pend;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_wb_pipe #(.DATA_W(16), .ADDR_W(4), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we),
      .wb_wdata(o1_wdata), .wb_waddr(o1_waddr), .wb_we(o1_we),
      .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
      .fwd_hit1(o1_hit1), .fwd_hit2(o1_hit2),
      .fwd_data1(o1_fdata1), .fwd_data2(o1_fdata2), .pending(o1_pend)
   );

   mem_wb_pipe #(.DATA_W(16), .ADDR_W(4), .STAGES(3)) dut3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we),
      .wb_wdata(o3_wdata), .wb_waddr(o3_waddr), .wb_we(o3_we),
      .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
      .fwd_hit1(o3_hit1), .fwd_hit2(o3_hit2),
      .fwd_data1(o3_fdata1), .fwd_data2(o3_fdata2), .pending(o3_pend)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [3:0] a, input logic [15:0] d);
      mem_we    = we;
      mem_waddr = a;
      mem_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 4'd3, 16'hFFFF);
      fwd_raddr1 = 4'd0; fwd_raddr2 = 4'd3;
      #12;
      checks++; if ({o1_we, o1_waddr, o1_wdata} !== 21'd0) begin errors++; $display("FAIL reset_wb1: got %h expected 0", {o1_we, o1_waddr, o1_wdata}); end
      checks++; if ({o3_we, o3_waddr, o3_wdata} !== 21'd0) begin errors++; $display("FAIL reset_wb3: got %h expected 0", {o3_we, o3_waddr, o3_wdata}); end
      checks++; if ({o1_pend, o3_pend} !== 6'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", {o1_pend, o3_pend}); end
      checks++; if ({o3_hit1, o3_hit2, o3_fdata1, o3_fdata2} !== 34'd0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", {o3_hit1, o3_hit2, o3_fdata1, o3_fdata2}); end
   endtask

   task automatic test_legacy();
      rst = 1'b1;
      drive(1'b1, 4'd1, 16'h0001);
      fwd_raddr1 = 4'd1;
      tick();
      checks++; if ({o1_we, o1_waddr, o1_wdata} !== {1'b1, 4'd1, 16'h0001}) begin errors++; $display("FAIL legacy_write: got %h expected %h", {o1_we, o1_waddr, o1_wdata}, {1'b1, 4'd1, 16'h0001}); end
      checks++; if ({o3_we, o3_pend, o3_hit1, o3_fdata1} !== {1'b0, 3'd1, 1'b1, 16'h0001}) begin errors++; $display("FAIL legacy_s3_fwd: got %h expected %h", {o3_we, o3_pend, o3_hit1, o3_fdata1}, {1'b0, 3'd1, 1'b1, 16'h0001}); end
      drive(1'b0, 4'd7, 16'hBEEF);
      tick();
      checks++; if ({o1_we, o1_waddr, o1_wdata, o1_pend} !== 24'd0) begin errors++; $display("FAIL legacy_idle: got %h expected 0", {o1_we, o1_waddr, o1_wdata, o1_pend}); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (o3_pend !== 3'd0) begin errors++; $display("FAIL legacy_flush_pend: got %0d expected 0", o3_pend); end
   endtask

   task automatic test_depth();
      logic [15:0] dv [3];
      dv[0] = 16'h0A11; dv[1] = 16'h0B22; dv[2] = 16'h0C33;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), dv[i]);
         tick();
         checks++; if (o3_pend !== 3'(i + 1)) begin errors++; $display("FAIL depth_pend_rise%0d: got %0d expected %0d", i, o3_pend, i + 1); end
      end
      drive(1'b0, 4'd0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         checks++; if ({o3_we, o3_waddr, o3_wdata} !== {1'b1, 4'(i + 1), dv[i]}) begin errors++; $display("FAIL depth_wb%0d: got %h expected %h", i, {o3_we, o3_waddr, o3_wdata}, {1'b1, 4'(i + 1), dv[i]}); end
         tick();
      end
      checks++; if ({o3_we, o3_pend} !== 4'd0) begin errors++; $display("FAIL depth_drained: got %h expected 0", {o3_we, o3_pend}); end
   endtask

   task automatic test_stall();
      logic [15:0] dv [3];
      dv[0] = 16'h1A01; dv[1] = 16'h1B02; dv[2] = 16'h1C03;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 8), dv[i]);
         tick();
      end
      drive(1'b1, 4'd7, 16'h0E55);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if ({o3_we, o3_waddr, o3_wdata, o3_pend} !== {1'b1, 4'd8, dv[0], 3'd3}) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, {o3_we, o3_waddr, o3_wdata, o3_pend}, {1'b1, 4'd8, dv[0], 3'd3}); end
      end
      stall = 1'b0;
      drive(1'b0, 4'd0, 16'h0);
      for (int i = 1; i < 3; i++) begin
         tick();
         checks++; if ({o3_we, o3_waddr, o3_wdata, o3_pend} !== {1'b1, 4'(i + 8), dv[i], 3'(3 - i)}) begin errors++; $display("FAIL stall_drain%0d: got %h expected %h", i, {o3_we, o3_waddr, o3_wdata, o3_pend}, {1'b1, 4'(i + 8), dv[i], 3'(3 - i)}); end
      end
      tick();
      checks++; if ({o3_we, o3_pend} !== 4'd0) begin errors++; $display("FAIL stall_empty: got %h expected 0", {o3_we, o3_pend}); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 1), 16'h5000 + 16'(i));
         tick();
      end
      drive(1'b1, 4'd4, 16'h0D44);
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      checks++; if ({o3_pend, o3_we, o3_wdata} !== 20'd0) begin errors++; $display("FAIL flush_clear3: got %h expected 0", {o3_pend, o3_we, o3_wdata}); end
      checks++; if ({o1_pend, o1_we} !== 4'd0) begin errors++; $display("FAIL flush_clear1: got %h expected 0", {o1_pend, o1_we}); end
      drive(1'b0, 4'd0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (o3_we !== 1'b0 || o3_wdata === 16'h0D44) begin errors++; $display("FAIL flush_discard%0d: got we=%b data=%h expected we=0", i, o3_we, o3_wdata); end
      end
   endtask

   task automatic test_forward();
      drive(1'b1, 4'd5, 16'h1111); tick();
      drive(1'b0, 4'd0, 16'h0);    tick();
      drive(1'b1, 4'd5, 16'h2222); tick();
      drive(1'b0, 4'd0, 16'h0);
      fwd_raddr1 = 4'd5; fwd_raddr2 = 4'd6;
      #1;
      checks++; if ({o3_hit1, o3_fdata1} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL fwd_youngest: got %h expected %h", {o3_hit1, o3_fdata1}, {1'b1, 16'h2222}); end
      checks++; if ({o3_hit2, o3_fdata2} !== 17'd0) begin errors++; $display("FAIL fwd_miss: got %h expected 0", {o3_hit2, o3_fdata2}); end
      checks++; if (o3_pend !== 3'd2) begin errors++; $display("FAIL fwd_pend: got %0d expected 2", o3_pend); end
      fwd_raddr2 = 4'd0;
      #1;
      checks++; if ({o3_hit2, o3_fdata2} !== 17'd0) begin errors++; $display("FAIL fwd_invalid_addr0: got %h expected 0", {o3_hit2, o3_fdata2}); end
      tick();
      checks++; if ({o3_hit1, o3_fdata1} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL fwd_after_shift: got %h expected %h", {o3_hit1, o3_fdata1}, {1'b1, 16'h2222}); end
      tick();
      fwd_raddr1 = 4'd5;
      #1;
      checks++; if ({o3_hit1, o3_fdata1} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL fwd_oldest_only: got %h expected %h", {o3_hit1, o3_fdata1}, {1'b1, 16'h2222}); end
      flush = 1'b1; tick(); flush = 1'b0;
   endtask

   task automatic test_async_reset();
      drive(1'b1, 4'd2, 16'hA0A0); tick();
      drive(1'b1, 4'd3, 16'hB0B0); tick();
      stall = 1'b1;
      tick();
      checks++; if (o3_pend !== 3'd2) begin errors++; $display("FAIL arst_preload: got %0d expected 2", o3_pend); end
      fwd_raddr1 = 4'd2; fwd_raddr2 = 4'd3;
      #3 rst = 1'b0;
      #1;
      checks++; if ({o3_pend, o3_we, o3_waddr, o3_wdata} !== 24'd0) begin errors++; $display("FAIL arst_wb: got %h expected 0", {o3_pend, o3_we, o3_waddr, o3_wdata}); end
      checks++; if ({o3_hit1, o3_hit2, o3_fdata1, o3_fdata2} !== 34'd0) begin errors++; $display("FAIL arst_fwd: got %h expected 0", {o3_hit1, o3_hit2, o3_fdata1, o3_fdata2}); end
      checks++; if ({o1_pend, o1_we, o1_wdata} !== 20'd0) begin errors++; $display("FAIL arst_wb1: got %h expected 0", {o1_pend, o1_we, o1_wdata}); end
      #1 rst = 1'b1;
      stall = 1'b0;
      drive(1'b1, 4'd9, 16'h3C3C);
      fwd_raddr1 = 4'd9;
      tick();
      checks++; if ({o3_pend, o3_hit1, o3_fdata1} !== {3'd1, 1'b1, 16'h3C3C}) begin errors++; $display("FAIL arst_fresh3: got %h expected %h", {o3_pend, o3_hit1, o3_fdata1}, {3'd1, 1'b1, 16'h3C3C}); end
      checks++; if ({o1_we, o1_waddr, o1_wdata} !== {1'b1, 4'd9, 16'h3C3C}) begin errors++; $display("FAIL arst_fresh1: got %h expected %h", {o1_we, o1_waddr, o1_wdata}, {1'b1, 4'd9, 16'h3C3C}); end
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_depth();
      test_stall();
      test_flush();
      test_forward();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
